// File: rtl/mac_pkg.sv
// ============================================================================
// Module      : mac_pkg
// Description : Shared state encoding and default widths for the MAC
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mac_pkg;

  localparam int BIT_WIDTH  = 8;
  localparam int ACCUM_BITS = 32;
  localparam int LEN_BITS   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : mac_pkg

`default_nettype wire

// File: rtl/mac_seq_ctrl.sv
// ============================================================================
// Module      : mac_seq_ctrl
// Description : Sequences operand pairs through an external MAC, feeding its
//               output back through an accumulator and returning the sum.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_seq_ctrl #(
  parameter int BIT_WIDTH  = mac_pkg::BIT_WIDTH,
  parameter int ACCUM_BITS = mac_pkg::ACCUM_BITS,
  parameter int LEN_BITS   = mac_pkg::LEN_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_BITS-1:0]   len,
  input  logic [ACCUM_BITS-1:0] bias,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIT_WIDTH-1:0]  weight_in,
  input  logic [BIT_WIDTH-1:0]  inp_in,
  output logic [BIT_WIDTH-1:0]  mac_weight,
  output logic [BIT_WIDTH-1:0]  mac_inp,
  output logic [ACCUM_BITS-1:0] mac_psum_in,
  input  logic [ACCUM_BITS-1:0] mac_psum_out,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [ACCUM_BITS-1:0] result,
  output logic                  busy,
  output logic [LEN_BITS-1:0]   pairs_done
);

  import mac_pkg::*;

  state_e                r_state;
  state_e                w_state_nxt;
  logic [ACCUM_BITS-1:0] r_acc;
  logic [ACCUM_BITS-1:0] r_result;
  logic [LEN_BITS-1:0]   r_count;
  logic [LEN_BITS-1:0]   r_len_q;

  logic w_job_start;
  logic w_accept;
  logic w_last;

  assign w_job_start = (r_state == IDLE) && start;
  assign w_accept    = (r_state == RUN) && in_valid;
  assign w_last      = w_accept && (r_count == (r_len_q - LEN_BITS'(1)));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = (len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (result_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready     = 1'b0;
    result_valid = 1'b0;
    busy         = 1'b0;
    case (r_state)
      RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      DONE: begin
        result_valid = 1'b1;
        busy         = 1'b1;
      end
      default: begin
        in_ready     = 1'b0;
        result_valid = 1'b0;
        busy         = 1'b0;
      end
    endcase
  end

  // The result register is loaded alongside acc on entry to DONE so it keeps
  // the previous job's value after the next job reloads acc with its bias.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= '0;
      r_result <= '0;
      r_count  <= '0;
      r_len_q  <= '0;
    end else if (w_job_start) begin
      r_acc   <= bias;
      r_len_q <= len;
      r_count <= '0;
      if (len == '0) begin
        r_result <= bias;
      end
    end else if (w_accept) begin
      r_acc   <= mac_psum_out;
      r_count <= r_count + LEN_BITS'(1);
      if (w_last) begin
        r_result <= mac_psum_out;
      end
    end
  end

  assign mac_weight  = weight_in;
  assign mac_inp     = inp_in;
  assign mac_psum_in = r_acc;
  assign result      = r_result;
  assign pairs_done  = r_count;

endmodule : mac_seq_ctrl

`default_nettype wire
